// File: rtl/array_pkg.sv
// Shared constants for the systolic array west-edge feeder: lane instruction
// codes, feeder FSM state encoding and default array geometry.
package array_pkg;

  localparam int DEF_ROW = 8;
  localparam int DEF_BW  = 4;

  // Per-lane instruction seen by a tile: bit1 = execute, bit0 = kernel load.
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

endpackage

// File: rtl/array_west_feeder_if.sv
// Row-wide vector stream from the L0/SRAM side into the west feeder.
// Handshake: a vector transfers on a rising clk edge where in_valid and
// in_ready are both high; the source holds in_data stable while in_valid is
// high, and in_ready never depends combinationally on in_valid.
interface array_west_feeder_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/feed_fifo.sv
// Synchronous FIFO holding row-wide vectors between the input stream and
// the skew pipeline. Read data is combinational from the head entry.
module feed_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wr_data,
  input  logic         pop,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  // The extra pointer bit separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // Pointer update; reset flushes the contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; entries need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/array_west_feeder.sv
// West-edge feeder for the weight-stationary MAC array. Buffers incoming
// vectors, issues k_len weight vectors then a_len activation vectors, and
// skews them so row r sees each vector r cycles after row 0.
module array_west_feeder
  import array_pkg::*;
#(
  parameter int ROW    = DEF_ROW,
  parameter int BW     = DEF_BW,
  parameter int DEPTH  = 16,
  parameter int LEN_BW = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [LEN_BW-1:0]   k_len,
  input  logic [LEN_BW-1:0]   a_len,
  array_west_feeder_if.slave  in_bus,
  output logic [ROW*BW-1:0]   out_w,
  output logic [2*ROW-1:0]    inst_w,
  output logic                busy,
  output logic                done,
  output state_t              dbg_state
);
  localparam int DW = (ROW > 2) ? $clog2(ROW) : 1;
  localparam logic [DW-1:0]     DRAIN_LAST = DW'(ROW - 2);
  localparam logic [LEN_BW-1:0] LEN_ONE    = LEN_BW'(1);

  state_t              state;
  logic [LEN_BW-1:0]   k_lat;
  logic [LEN_BW-1:0]   a_lat;
  logic [LEN_BW-1:0]   cnt;
  logic [LEN_BW-1:0]   cnt_nxt;
  logic [DW-1:0]       drain_cnt;
  logic [ROW*BW-1:0]   fifo_q;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [1:0]          issue_inst;

  assign in_bus.in_ready = !fifo_full;
  assign push            = in_bus.in_valid && !fifo_full;
  assign cnt_nxt         = cnt + LEN_ONE;
  assign dbg_state       = state;

  feed_fifo #(.W(ROW*BW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (in_bus.in_data),
    .pop     (pop),
    .rd_data (fifo_q),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Instruction entering lane 0 this cycle; an empty FIFO yields a bubble.
  always_comb begin
    issue_inst = INST_IDLE;
    if (!fifo_empty) begin
      if (state == ST_LOAD)      issue_inst = INST_LOAD;
      else if (state == ST_EXEC) issue_inst = INST_EXEC;
    end
  end

  assign pop = (issue_inst != INST_IDLE);

  // Pass sequencing: load weights, one gap cycle, execute, then drain the skew.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      k_lat     <= '0;
      a_lat     <= '0;
      cnt       <= '0;
      drain_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            k_lat     <= k_len;
            a_lat     <= a_len;
            cnt       <= '0;
            drain_cnt <= '0;
            busy      <= 1'b1;
            if (k_len != '0)      state <= ST_LOAD;
            else if (a_len != '0) state <= ST_EXEC;
            else                  state <= ST_DRAIN;
          end
        end
        ST_LOAD: begin
          if (pop) begin
            if (cnt_nxt == k_lat) begin
              cnt   <= '0;
              state <= ST_GAP;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        ST_GAP: begin
          state <= (a_lat != '0) ? ST_EXEC : ST_DRAIN;
        end
        ST_EXEC: begin
          if (pop) begin
            if (cnt_nxt == a_lat) begin
              cnt   <= '0;
              state <= ST_DRAIN;
            end else begin
              cnt <= cnt_nxt;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= ST_IDLE;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Per-row skew: lane r is r+1 registers deep and carries only its slice.
  for (genvar r = 0; r < ROW; r++) begin : g_lane
    logic [BW-1:0] d_q [r+1];
    logic [1:0]    i_q [r+1];

    // Shift inst and data together; data holds through bubbles.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i <= r; i++) begin
          d_q[i] <= '0;
          i_q[i] <= INST_IDLE;
        end
      end else begin
        i_q[0] <= issue_inst;
        if (issue_inst != INST_IDLE) d_q[0] <= fifo_q[r*BW +: BW];
        for (int i = 1; i <= r; i++) begin
          i_q[i] <= i_q[i-1];
          if (i_q[i-1] != INST_IDLE) d_q[i] <= d_q[i-1];
        end
      end
    end

    assign out_w[r*BW +: BW] = d_q[r];
    assign inst_w[2*r +: 2]  = i_q[r];
  end

endmodule

// File: tb/tb_array_west_feeder.sv
// Self-checking bench for array_west_feeder: directed passes with random
// data, checked against a closed-form timeline and per-lane scoreboards.
module tb_array_west_feeder;
  import array_pkg::*;

  localparam int ROW = 8;
  localparam int BW  = 4;
  localparam int W   = ROW * BW;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [7:0]    k_len;
  logic [7:0]    a_len;
  logic [W-1:0]  out_w;
  logic [2*ROW-1:0] inst_w;
  logic          busy;
  logic          done;
  state_t        dbg_state;

  array_west_feeder_if #(.W(W)) bus ();

  array_west_feeder #(.ROW(ROW), .BW(BW), .DEPTH(16), .LEN_BW(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .k_len     (k_len),
    .a_len     (a_len),
    .in_bus    (bus),
    .out_w     (out_w),
    .inst_w    (inst_w),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [W-1:0]    vec [0:31];
  logic [BW+1:0]   exp_q [ROW][$];

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_out_w"},  out_w, '0);
    chk({tag, "_inst_w"}, inst_w, '0);
    chk({tag, "_busy"},   busy, 1'b0);
    chk({tag, "_done"},   done, 1'b0);
    chk({tag, "_ready"},  bus.in_ready, 1'b1);
    chk({tag, "_state"},  dbg_state, ST_IDLE);
  endtask

  // One pass. The first `pre` vectors are pushed before start; the rest are
  // pushed from cycle resume_t on. Cycle t counts from the edge that takes
  // start. With `timed`, lane r at cycle t must show lane-0's cycle t-r item,
  // where lane 0 shows weight i at cycle i+1, activation j at cycle e0+1+j
  // (e0 = k+1, or 0 without weights), and done lands at e0+a+ROW-1.
  task automatic run_pass(input int k, input int a, input int pre, input int resume_t,
                          input bit timed, input int restart_t, input int stop_t,
                          input int exp_bub);
    int idx, e0, dn, t, u, bub;
    int n01 [ROW];
    bit fin;
    logic [1:0]    li, ei;
    logic [BW-1:0] ld;
    logic [W-1:0]  ev;
    logic [BW+1:0] e;
    idx = 0;
    while (idx < pre) begin
      bus.in_valid = 1'b1;
      bus.in_data  = vec[idx];
      idx++;
      tick();
    end
    bus.in_valid = 1'b0;
    start = 1'b1;
    k_len = 8'(k);
    a_len = 8'(a);
    e0 = (k > 0) ? k + 1 : 0;
    dn = e0 + a + ROW - 1;
    bub = 0;
    for (int r = 0; r < ROW; r++) begin
      n01[r] = 0;
      exp_q[r].delete();
      for (int i = 0; i < k; i++) exp_q[r].push_back({INST_LOAD, vec[i][r*BW +: BW]});
      for (int i = 0; i < a; i++) exp_q[r].push_back({INST_EXEC, vec[k+i][r*BW +: BW]});
    end
    t = 0;
    fin = 1'b0;
    while (!fin) begin
      tick();
      start = 1'b0;
      bus.in_valid = 1'b0;
      for (int r = 0; r < ROW; r++) begin
        li = inst_w[2*r +: 2];
        ld = out_w[r*BW +: BW];
        if (timed) begin
          u = t - r;
          ei = INST_IDLE;
          ev = '0;
          if (u >= 1 && u <= k) begin
            ei = INST_LOAD;
            ev = vec[u-1];
          end else if (u >= e0 + 1 && u <= e0 + a) begin
            ei = INST_EXEC;
            ev = vec[k + u - e0 - 1];
          end
          chk("lane_inst", li, ei);
          if (ei != INST_IDLE) chk("lane_data", ld, ev[r*BW +: BW]);
        end
        if (r == 0 && li == INST_IDLE && n01[0] > 0 && n01[0] < k) bub++;
        if (li != INST_IDLE) begin
          if (exp_q[r].size() == 0) chk("sb_extra", li, INST_IDLE);
          else begin
            e = exp_q[r].pop_front();
            chk("sb_lane", {li, ld}, e);
          end
        end
        if (li == INST_LOAD) n01[r]++;
      end
      if (timed) begin
        chk("done_time", done, t == dn);
        chk("busy_time", busy, t < dn);
      end else begin
        chk("busy_vs_done", busy, !done);
      end
      if (t == restart_t) begin
        start = 1'b1;
        k_len = 8'd1;
        a_len = 8'd1;
      end
      if (t >= resume_t - 1 && idx < k + a) begin
        chk("ready_in_pass", bus.in_ready, 1'b1);
        bus.in_valid = 1'b1;
        bus.in_data  = vec[idx];
        idx++;
      end
      if (done || t == stop_t) fin = 1'b1;
      if (t > 300) begin
        chk("timeout_done", done, 1'b1);
        fin = 1'b1;
      end
      t++;
    end
    start = 1'b0;
    if (stop_t < 0) begin
      for (int r = 0; r < ROW; r++) begin
        chk("load_pulses", n01[r], k);
        chk("sb_left", exp_q[r].size(), 0);
      end
      chk("idle_after", dbg_state, ST_IDLE);
      if (exp_bub >= 0) chk("bubbles", bub, exp_bub);
    end
  endtask

  initial begin
    // Reset held 3 cycles with in_valid asserted: nothing may be pushed.
    reset = 1'b1;
    start = 1'b0;
    k_len = '0;
    a_len = '0;
    bus.in_valid = 1'b1;
    bus.in_data  = '1;
    repeat (3) begin
      tick();
      chk_quiet("rst");
    end
    reset = 1'b0;
    bus.in_valid = 1'b0;
    tick();
    chk_quiet("post_rst");

    // Backpressure: 16 pushes fill it, 17th is refused.
    for (int i = 0; i < 16; i++) begin
      vec[i] = $urandom;
      chk("bp_ready", bus.in_ready, 1'b1);
      bus.in_valid = 1'b1;
      bus.in_data  = vec[i];
      tick();
    end
    chk("bp_full", bus.in_ready, 1'b0);
    bus.in_data = $urandom;
    repeat (2) begin
      tick();
      chk("bp_hold", bus.in_ready, 1'b0);
    end
    bus.in_valid = 1'b0;
    run_pass(10, 6, 0, 1000, 1'b1, -1, -1, -1);

    // Main pass with lane r of vector v = v+r, plus an ignored mid-pass start.
    for (int v = 0; v < 12; v++)
      for (int r = 0; r < ROW; r++) vec[v][r*BW +: BW] = BW'((v + r) % 16);
    run_pass(8, 4, 12, 1000, 1'b1, 3, -1, -1);

    // Random lengths and data.
    repeat (3) begin
      int k, a;
      k = $urandom_range(0, 6);
      a = $urandom_range(0, 8);
      for (int i = 0; i < k + a; i++) vec[i] = $urandom;
      run_pass(k, a, k + a, 1000, 1'b1, -1, -1, -1);
    end

    // Starvation: 3 weights up front, the rest from cycle 8 -> 5 bubbles.
    for (int i = 0; i < 10; i++) vec[i] = $urandom;
    run_pass(8, 2, 3, 8, 1'b0, -1, -1, 5);

    // Degenerate lengths; the (0,0) pass must leave its preloaded vector.
    for (int i = 0; i < 3; i++) vec[i] = $urandom;
    run_pass(0, 3, 3, 1000, 1'b1, -1, -1, -1);
    vec[0] = $urandom;
    run_pass(0, 0, 1, 1000, 1'b1, -1, -1, -1);
    run_pass(1, 0, 0, 1000, 1'b1, -1, -1, -1);

    // Abort mid-execute (cycle 5 of k=2,a=6), then prove the FIFO was flushed.
    for (int i = 0; i < 8; i++) vec[i] = $urandom;
    run_pass(2, 6, 8, 1000, 1'b0, -1, 5, -1);
    chk("abort_in_exec", dbg_state, ST_EXEC);
    reset = 1'b1;
    tick();
    chk_quiet("abort");
    reset = 1'b0;
    repeat (10) begin
      tick();
      chk("abort_no_done", done, 1'b0);
      chk("abort_no_inst", inst_w, '0);
    end
    vec[0] = $urandom;
    run_pass(0, 1, 1, 1000, 1'b1, -1, -1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
